collatz_steps: RTL and testbench



---
 rtl/collatz_steps_pkg.sv | 22 ++
 rtl/collatz_steps_step.sv | 20 ++
 rtl/collatz_steps.sv | 69 ++++++
 tb/tb_collatz_steps.sv | 119 +++++++++++
 4 files changed

// File: rtl/collatz_steps_pkg.sv
// Shared primitives for the valid-tagged integer bus: width, valid index, bus type and FSM states.
package collatz_steps_pkg;

   localparam int INT_N = 16;
   localparam int INT_R = INT_N;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef logic [INT_N:0] int_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int_t read(input logic [INT_N-1:0] x);
      return {TRUE, x};
   endfunction

endpackage

// File: rtl/collatz_steps_step.sv
// One combinational Collatz step: n/2 when even, 3n+1 (wrapping to N bits) when odd.
// is_done flags the terminal values 0 and 1.
module collatz_steps_step #(
   parameter int N = 16
) (
   input  logic [N-1:0] n,
   output logic [N-1:0] nxt,
   output logic         is_done
);

   always_comb begin
      is_done = (n <= N'(1));
      if (n[0]) begin
         nxt = (n << 1) + n + N'(1);
      end else begin
         nxt = n >> 1;
      end
   end

endmodule

// File: rtl/collatz_steps.sv
// Iterative Collatz step counter; one step per clock, result valid k+1 cycles after acceptance.
// Requests arriving while busy are dropped, not queued; b is fully registered.
module collatz_steps
   import collatz_steps_pkg::*;
#(
   parameter int N = INT_N
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [N:0] a,
   output logic [N:0] b
);

   state_t       state, state_nxt;
   logic [N-1:0] n, n_nxt;
   logic [N-1:0] count, count_nxt;
   logic [N:0]   b_nxt;
   logic [N-1:0] step_n;
   logic         step_done;

   collatz_steps_step #(.N(N)) u_step (
      .n       (n),
      .nxt     (step_n),
      .is_done (step_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         n     <= '0;
         count <= '0;
         b     <= '0;
      end else begin
         state <= state_nxt;
         n     <= n_nxt;
         count <= count_nxt;
         b     <= b_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      n_nxt     = n;
      count_nxt = count;
      b_nxt     = b;
      case (state)
         IDLE, DONE: begin
            // Only the valid flag drops on a new request; stale data stays until the result lands.
            if (a[N]) begin
               n_nxt     = a[N-1:0];
               count_nxt = '0;
               b_nxt[N]  = FALSE;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (step_done) begin
               b_nxt     = {TRUE, count};
               state_nxt = DONE;
            end else begin
               n_nxt     = step_n;
               count_nxt = count + N'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_collatz_steps.sv
// Directed bench for collatz_steps: hand-computed step counts, latency, ignore-while-busy and reset.
module tb_collatz_steps;
   import collatz_steps_pkg::*;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [N:0] a;
   logic [N:0] b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   collatz_steps #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [N-1:0] v);
      a = read(v);
      tick();
      a = '0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!b[N] && cyc < 2000);
   endtask

   task automatic run_vec(input string tag, input logic [N-1:0] v, input int steps);
      int cyc;
      pulse(v);
      chk({tag, "_busy"}, 32'(b[N]), 32'd0);
      wait_done(cyc);
      chk({tag, "_lat"}, 32'(cyc), 32'(steps + 1));
      chk({tag, "_res"}, 32'(b), 32'({1'b1, 16'(steps)}));
   endtask

   initial begin
      int         cyc;
      int         changes;
      logic [N:0] held;

      rst = 1'b1;
      a   = '0;
      tick();
      tick();
      chk("rst_b", 32'(b), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_b", 32'(b), 32'd0);

      // 27 takes 111 steps; result must then hold while a stays idle
      run_vec("n27", 16'd27, 111);
      held    = b;
      changes = 0;
      repeat (12) begin
         tick();
         if (b !== held) changes++;
      end
      chk("hold27", 32'(changes), 32'd0);

      run_vec("n6", 16'd6, 8);
      run_vec("n7", 16'd7, 16);
      run_vec("n1", 16'd1, 0);
      run_vec("n0", 16'd0, 0);
      // 43691 is odd: 3n+1 = 0x20002 wraps to 2, then 2 -> 1
      run_vec("wrap", 16'd43691, 2);

      // a request for 6 mid-RUN must be dropped
      pulse(16'd27);
      repeat (30) tick();
      a = read(16'd6);
      tick();
      a = '0;
      wait_done(cyc);
      chk("ign_lat", 32'(cyc + 31), 32'd112);
      chk("ign_res", 32'(b), 32'({1'b1, 16'd111}));

      run_vec("done6", 16'd6, 8);

      // reset in the middle of a run
      pulse(16'd27);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      chk("midrst_b", 32'(b), 32'd0);
      chk("midrst_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      repeat (3) tick();
      chk("postrst_idle", 32'(b), 32'd0);
      run_vec("post7", 16'd7, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
